// File: rtl/id_ex_stage_pkg.sv
// Shared control encodings for the ID/EX pipeline register: ALU op codes,
// control-bit positions and the packed control word.
package id_ex_stage_pkg;

   localparam int unsigned REGW   = 5;
   localparam int unsigned ALUOPW = 5;
   localparam int unsigned CTRLW  = 6;

   // Bit positions inside the 6-bit control word {RegWrite, MemRead, MemWrite, ALUSrc, WDSel[1:0]}
   localparam int unsigned CTRL_REGWRITE = 5;
   localparam int unsigned CTRL_MEMREAD  = 4;
   localparam int unsigned CTRL_MEMWRITE = 3;
   localparam int unsigned CTRL_ALUSRC   = 2;
   localparam int unsigned CTRL_WDSEL    = 0;
   localparam int unsigned CTRL_WDSEL_W  = 2;

   typedef enum logic [ALUOPW-1:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_SLL  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_SLT  = 5'd8,
      ALU_SLTU = 5'd9,
      ALU_LUI  = 5'd10
   } aluop_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic [1:0] wd_sel;
   } ctrl_t;

   function automatic logic is_load(input logic [CTRLW-1:0] ctrl);
      return ctrl[CTRL_MEMREAD];
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: ID-side inputs, registered EX-side outputs,
// hazard stall and event counters.
interface id_ex_stage_if
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned CNTW = 16
) ();

   logic              id_valid;
   logic [XLEN-1:0]   id_pc;
   logic [XLEN-1:0]   id_rd1;
   logic [XLEN-1:0]   id_rd2;
   logic [XLEN-1:0]   id_imm;
   logic [REGW-1:0]   id_rs1;
   logic [REGW-1:0]   id_rs2;
   logic [REGW-1:0]   id_rd;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [ALUOPW-1:0] id_aluop;
   logic [CTRLW-1:0]  id_ctrl;
   logic              flush_i;

   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc;
   logic [XLEN-1:0]   ex_rd1;
   logic [XLEN-1:0]   ex_rd2;
   logic [XLEN-1:0]   ex_imm;
   logic [REGW-1:0]   ex_rs1;
   logic [REGW-1:0]   ex_rs2;
   logic [REGW-1:0]   ex_rd;
   logic [ALUOPW-1:0] ex_aluop;
   logic [CTRLW-1:0]  ex_ctrl;
   logic              stall_o;
   logic [CNTW-1:0]   stall_cnt;
   logic [CNTW-1:0]   flush_cnt;

   modport master (
      output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
             id_use_rs1, id_use_rs2, id_aluop, id_ctrl, flush_i,
      input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_aluop, ex_ctrl, stall_o, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
             id_use_rs1, id_use_rs2, id_aluop, id_ctrl, flush_i,
      output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_aluop, ex_ctrl, stall_o, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction in ID forces a one-cycle stall, unless EX is flushing.
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic            id_valid,
   input  logic            id_use_rs1,
   input  logic            id_use_rs2,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic            ex_valid,
   input  logic            ex_mem_read,
   input  logic [REGW-1:0] ex_rd,
   input  logic            flush,
   output logic            stall
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

   // x0 never carries a produced value, so a load to x0 cannot cause a hazard
   assign stall = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                  && (rs1_hit || rs2_hit) && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush handling and
// saturating stall/flush event counters.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned CNTW = 16
) (
   input  logic         clk,
   input  logic         rst,
   id_ex_stage_if.slave bus
);

   logic stall;
   logic bubble;

   hazard_detect u_hazard (
      .id_valid    (bus.id_valid),
      .id_use_rs1  (bus.id_use_rs1),
      .id_use_rs2  (bus.id_use_rs2),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .ex_valid    (bus.ex_valid),
      .ex_mem_read (is_load(bus.ex_ctrl)),
      .ex_rd       (bus.ex_rd),
      .flush       (bus.flush_i),
      .stall       (stall)
   );

   assign bus.stall_o = stall;
   // Flush and stall both insert the same bubble; stall is already masked by flush
   assign bubble      = bus.flush_i || stall;

   // Pipeline register: datapath fields always follow ID, control is qualified
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ex_valid <= 1'b0;
         bus.ex_pc    <= XLEN'(0);
         bus.ex_rd1   <= XLEN'(0);
         bus.ex_rd2   <= XLEN'(0);
         bus.ex_imm   <= XLEN'(0);
         bus.ex_rs1   <= REGW'(0);
         bus.ex_rs2   <= REGW'(0);
         bus.ex_rd    <= REGW'(0);
         bus.ex_aluop <= ALUOPW'(0);
         bus.ex_ctrl  <= CTRLW'(0);
      end else begin
         bus.ex_pc  <= bus.id_pc;
         bus.ex_rd1 <= bus.id_rd1;
         bus.ex_rd2 <= bus.id_rd2;
         bus.ex_imm <= bus.id_imm;
         bus.ex_rs1 <= bus.id_rs1;
         bus.ex_rs2 <= bus.id_rs2;
         if (bubble) begin
            bus.ex_valid <= 1'b0;
            bus.ex_rd    <= REGW'(0);
            bus.ex_aluop <= ALUOPW'(0);
            bus.ex_ctrl  <= CTRLW'(0);
         end else begin
            bus.ex_valid <= bus.id_valid;
            bus.ex_rd    <= bus.id_rd;
            bus.ex_aluop <= bus.id_valid ? bus.id_aluop : ALUOPW'(0);
            bus.ex_ctrl  <= bus.id_valid ? bus.id_ctrl  : CTRLW'(0);
         end
      end
   end

   // Saturating event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.stall_cnt <= CNTW'(0);
         bus.flush_cnt <= CNTW'(0);
      end else begin
         if (stall && (bus.stall_cnt != '1)) begin
            bus.stall_cnt <= bus.stall_cnt + CNTW'(1);
         end
         if (bus.flush_i && (bus.flush_cnt != '1)) begin
            bus.flush_cnt <= bus.flush_cnt + CNTW'(1);
         end
      end
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and asynchronous active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-002 SHALL have parameter XLEN, default 32, datapath width.
REQ-003 SHALL have parameter CNTW, default 16, event-counter width.
REQ-004 id_valid input 1: decode slot holds a real instruction.
REQ-005 id_pc, id_rd1, id_rd2, id_imm inputs XLEN: decode PC, register-file data, extended immediate.
REQ-006 id_rs1, id_rs2, id_rd inputs 5: source and destination register indices.
REQ-007 id_use_rs1, id_use_rs2 inputs 1: instruction actually reads rs1/rs2.
REQ-008 id_aluop input 5: ALU operation code, same encoding the ALU consumes.
REQ-009 id_ctrl input 6: {RegWrite, MemRead, MemWrite, ALUSrc, WDSel[1:0]}.
REQ-010 flush_i input 1: branch/jump-taken flush, from the ALU in EX.
REQ-011 ex_valid output 1; ex_pc, ex_rd1, ex_rd2, ex_imm outputs XLEN; ex_rs1, ex_rs2, ex_rd outputs 5; ex_aluop output 5; ex_ctrl output 6: registered EX-stage bundle.
REQ-012 stall_o output 1: load-use hazard; IF/ID and PC hold when high.
REQ-013 stall_cnt, flush_cnt outputs CNTW: saturating event counters.

Function
REQ-014 Output registers SHALL update on the rising clk edge; they SHALL have 1-cycle latency from id_* to ex_*.
REQ-015 stall_o SHALL be combinational: id_valid & ex_valid & ex_ctrl.MemRead & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) & !flush_i.
REQ-016 Next-state priority SHALL be flush_i > stall_o > normal load.
REQ-017 On flush_i=1, the register SHALL load a bubble: ex_valid=0, ex_ctrl=0, ex_aluop=0, ex_rd=0; datapath fields are don't-care.
REQ-018 On stall_o=1 (no flush), the register SHALL load a bubble identical to REQ-017.
REQ-019 Otherwise, all ex_* fields SHALL take the id_* values, with ex_valid=id_valid.
REQ-020 When id_valid=0, ex_ctrl and ex_aluop SHALL be forced to 0, so that no register or memory write leaks.
REQ-021 stall_o SHALL never be high for two consecutive cycles caused by the same load, because the bubble clears ex_ctrl.MemRead.
REQ-022 stall_cnt SHALL increment on each cycle with stall_o=1 and SHALL saturate at all-ones.
REQ-023 flush_cnt SHALL increment on each cycle with flush_i=1 and SHALL saturate at all-ones, with no wrap-around.
REQ-024 When flush_i and a hazard condition coincide, the block SHALL flush, keep stall_o=0, and count only the flush.

Reset
REQ-025 While rst=1, all ex_* outputs SHALL be 0, and stall_cnt and flush_cnt SHALL be 0.
REQ-026 Reset assertion SHALL take effect immediately, independent of clk.
REQ-027 stall_o SHALL be 0 while in reset, because ex_valid=0.
REQ-028 Reset asserted mid-stall SHALL discard the pending instruction.
REQ-029 The first edge after rst deasserts SHALL load normally.

Structure
REQ-030 ALUOp codes and ctrl bit positions (CTRL_REGWRITE..CTRL_WDSEL) SHALL live in the shared control-encoding definitions file.
REQ-031 The hazard comparator SHALL be sub-module hazard_detect (combinational); the pipeline register and counters SHALL stay in id_ex_stage.

Verification
REQ-032 Reset: rst=1 with id_valid=1 and id_ctrl=6'h3F -> all ex_*=0, stall_o=0, counters=0.
REQ-033 Pass-through: id_pc=0x100, id_aluop=add, id_ctrl RegWrite=1, id_rd=5 -> next cycle ex_pc=0x100, ex_rd=5, ex_valid=1.
REQ-034 Load-use: lw x5 in EX, then id_rs1=5 with id_use_rs1=1 -> stall_o=1 for exactly 1 cycle, then a bubble (ex_valid=0), stall_cnt=1; the next instruction then loads.
REQ-035 x0 and no-use cases: lw x0, or id_use_rs1=0 with a matching index -> stall_o=0.
REQ-036 Flush vs stall: hazard condition with flush_i=1 -> stall_o=0, ex_valid=0 next cycle, flush_cnt=1, stall_cnt unchanged.
REQ-037 Saturation: with CNTW=4, flush_i held for 20 cycles -> flush_cnt=4'hF and stays there.
